sub_halt_ctrl: RTL

Main-CPU-side controller for the FM-7 main/sub shared RAM. It decodes main-CPU accesses to the sub-system control register ($FD05) and the shared window ($FC80–$FCFF). It runs the halt handshake with the sub 6809: request the halt, wait for the bus to be granted, release it. While the sub CPU is halted it drives the grant/select strobes that let the shared-RAM block take address and data from the main bus. It also holds the sub-CPU cancel-interrupt latch.

---
 rtl/fm7_sub_pkg.sv | 26 ++
 rtl/sub_ack_filter.sv | 35 +++
 rtl/sub_halt_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fm7_sub_pkg.sv
// Shared definitions for the FM-7 main/sub shared-RAM controller.
package fm7_sub_pkg;

  typedef enum logic [1:0] {
    StRun,
    StReq,
    StHalted,
    StRel
  } halt_state_e;

  localparam logic [15:0] FD05_ADDR        = 16'hFD05;
  localparam logic [15:0] WIN_BASE_DEFAULT = 16'hFC80;
  localparam logic [15:0] WIN_SIZE         = 16'd128;

  localparam int unsigned HALT_BIT   = 7;
  localparam int unsigned CANCEL_BIT = 6;
  localparam int unsigned ACK_CNT_W  = 3;

  // Offset arithmetic wraps, so a base near $FFFF still decodes a contiguous window.
  function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
    logic [15:0] offset;
    offset = addr - base;
    return offset < WIN_SIZE;
  endfunction

endpackage

// File: rtl/sub_ack_filter.sv
// Saturating run-length filter on the sub CPU halt acknowledge (SBA & SBS).
module sub_ack_filter
  import fm7_sub_pkg::*;
#(
  parameter int unsigned LIMIT = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_ack,
  output logic o_done
);

  localparam logic [ACK_CNT_W-1:0] LIMIT_W = ACK_CNT_W'(LIMIT);
  localparam logic [ACK_CNT_W-1:0] CNT_MAX = '1;

  logic [ACK_CNT_W-1:0] r_count;
  logic [ACK_CNT_W-1:0] w_count_inc;
  logic                 w_counting;

  assign w_counting  = i_en && i_ack;
  assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst || !w_counting) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_inc;
    end
  end

  // Done looks at the value being counted this cycle so the FSM can leave REQ on the same edge.
  assign o_done = w_counting && (w_count_inc >= LIMIT_W);

endmodule

// File: rtl/sub_halt_ctrl.sv
// Main-CPU side halt handshake, shared window decode and cancel latch for the FM-7 sub system.
module sub_halt_ctrl
  import fm7_sub_pkg::*;
#(
  parameter int unsigned  ACK_FILTER = 2,
  parameter logic [15:0]  WIN_BASE   = WIN_BASE_DEFAULT
) (
  input  logic        CLKSYS,
  input  logic        RESET,
  input  logic [15:0] MADDRBUS,
  input  logic [7:0]  MDATA_in,
  output logic [7:0]  MDATA_out,
  input  logic        MRDQEn,
  input  logic        MWTQEn,
  input  logic [7:0]  SRDATA_in,
  input  logic        SBA,
  input  logic        SBS,
  input  logic        SCANACKn,
  output logic        SHALTn,
  output logic        SHALTACn,
  output logic        SUBSELn,
  output logic        SCANCELn
);

  halt_state_e r_state;
  logic        r_shaltn;
  logic        r_shaltacn;
  logic        r_cancel;

  logic w_fd05_sel;
  logic w_fd05_wr;
  logic w_halt_set;
  logic w_halt_clr;
  logic w_in_win;
  logic w_ack_done;
  logic w_busy;
  logic w_unused_data;

  assign w_fd05_sel = (MADDRBUS == FD05_ADDR);
  assign w_fd05_wr  = w_fd05_sel && !MWTQEn;
  assign w_halt_set = w_fd05_wr && MDATA_in[HALT_BIT];
  assign w_halt_clr = w_fd05_wr && !MDATA_in[HALT_BIT];
  assign w_in_win   = in_window(MADDRBUS, WIN_BASE);
  assign w_busy     = (r_state != StHalted);

  assign w_unused_data = ^MDATA_in[CANCEL_BIT-1:0];

  sub_ack_filter #(
    .LIMIT (ACK_FILTER)
  ) u_ack_filter (
    .i_clk  (CLKSYS),
    .i_rst  (RESET),
    .i_en   (r_state == StReq),
    .i_ack  (SBA && SBS),
    .o_done (w_ack_done)
  );

  // Strobes are registered alongside the state so the grant never glitches.
  always_ff @(posedge CLKSYS) begin
    if (RESET) begin
      r_state    <= StRun;
      r_shaltn   <= 1'b1;
      r_shaltacn <= 1'b1;
    end else begin
      case (r_state)
        StRun: begin
          if (w_halt_set) begin
            r_state  <= StReq;
            r_shaltn <= 1'b0;
          end
        end
        StReq: begin
          if (w_halt_clr) begin
            r_state <= StRel;
          end else if (w_ack_done) begin
            r_state    <= StHalted;
            r_shaltacn <= 1'b0;
          end
        end
        StHalted: begin
          if (w_halt_clr) begin
            r_state    <= StRel;
            r_shaltacn <= 1'b1;
          end
        end
        StRel: begin
          r_state  <= StRun;
          r_shaltn <= 1'b1;
        end
        default: begin
          r_state    <= StRun;
          r_shaltn   <= 1'b1;
          r_shaltacn <= 1'b1;
        end
      endcase
    end
  end

  // Set has priority over the sub-side acknowledge.
  always_ff @(posedge CLKSYS) begin
    if (RESET) begin
      r_cancel <= 1'b0;
    end else if (w_fd05_wr && MDATA_in[CANCEL_BIT]) begin
      r_cancel <= 1'b1;
    end else if (!SCANACKn) begin
      r_cancel <= 1'b0;
    end
  end

  always_comb begin
    MDATA_out = 8'hFF;
    if (!MRDQEn) begin
      if (w_fd05_sel) begin
        MDATA_out = {w_busy, 7'h7F};
      end else if (w_in_win && !r_shaltacn) begin
        MDATA_out = SRDATA_in;
      end
    end
  end

  assign SUBSELn  = r_shaltacn || (MRDQEn && MWTQEn) || !w_in_win;
  assign SHALTn   = r_shaltn;
  assign SHALTACn = r_shaltacn;
  assign SCANCELn = !r_cancel;

endmodule
